// File: rtl/msk_stream_modulator_pkg.sv
// rtl/msk_stream_modulator_pkg.sv - shared types, constants and sine-table generator for the MSK modulator
package msk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } msk_state_t;

    // pi scaled by 2^30, used by the fixed-point sine series below
    localparam longint MSK_PI_Q30 = 64'sd3373259426;

    function automatic int msk_mid(input int sw);
        return 1 << (sw - 1);
    endfunction

    function automatic int msk_amp(input int sw);
        return (1 << (sw - 1)) - 1;
    endfunction

    // MID + round(AMP * sin(2*pi*i/p)); folded to the first quadrant so the
    // series converges fast and rounding is symmetric about MID
    function automatic int msk_sine(input int i, input int p, input int sw);
        int     half;
        int     j;
        bit     neg;
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint mag;
        half = p / 2;
        j    = i % p;
        neg  = 1'b0;
        if (j >= half) begin
            neg = 1'b1;
            j   = j - half;
        end
        if (2 * j > half) begin
            j = half - j;
        end
        x    = (2 * MSK_PI_Q30 * j) / p;
        x2   = (x * x) >>> 30;
        acc  = x;
        term = x;
        for (int n = 1; n <= 9; n++) begin
            term = -(((term * x2) >>> 30) / ((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        mag = (msk_amp(sw) * acc + (64'sd1 <<< 29)) >>> 30;
        return neg ? msk_mid(sw) - int'(mag) : msk_mid(sw) + int'(mag);
    endfunction

endpackage

// File: rtl/msk_stream_modulator_if.sv
// rtl/msk_stream_modulator_if.sv - word input and sample output handshake bundle
interface msk_stream_modulator_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic [SAMPLE_WIDTH-1:0] out_sample;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_sample
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_sample
    );
endinterface

// File: rtl/msk_stream_modulator_sine_lut.sv
// rtl/msk_stream_modulator_sine_lut.sv - combinational offset-binary sine table, P = 2*(N-1) entries
module msk_sine_lut
    import msk_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 8,
    parameter int SAMPLES_PER_BIT = 32
) (
    input  logic [$clog2(2*(SAMPLES_PER_BIT-1))-1:0] idx,
    output logic [SAMPLE_WIDTH-1:0]                  sample
);
    localparam int P = 2 * (SAMPLES_PER_BIT - 1);

    logic [SAMPLE_WIDTH-1:0] lut [P];

    for (genvar g = 0; g < P; g++) begin : g_tab
        assign lut[g] = SAMPLE_WIDTH'(msk_sine(g, P, SAMPLE_WIDTH));
    end

    assign sample = lut[idx];
endmodule

// File: rtl/msk_stream_modulator.sv
// rtl/msk_stream_modulator.sv - streaming continuous-phase MSK modulator, LSB-first, N samples per bit
module msk_stream_modulator
    import msk_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int SAMPLE_WIDTH    = 8,
    parameter int SAMPLES_PER_BIT = 32
) (
    input  logic                    G_CLK_TX,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    msk_stream_modulator_if.slave   strm,
    output logic                    busy,
    output logic                    phase
);
    localparam int N  = SAMPLES_PER_BIT;
    localparam int DW = DATA_WIDTH;
    localparam int SW = SAMPLE_WIDTH;
    localparam int P  = 2 * (N - 1);
    localparam int IW = $clog2(P) + 1;
    localparam int LW = $clog2(P);
    localparam int KW = $clog2(N);
    localparam int BW = $clog2(DW);

    localparam logic [IW-1:0] P_I    = IW'(P);
    localparam logic [IW-1:0] HALF_I = IW'(N - 1);
    localparam logic [SW-1:0] MID_S  = SW'(msk_mid(SW));
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DW - 1);

    msk_state_t      state;
    logic [DW-1:0]   shreg;
    logic [KW-1:0]   k;
    logic [BW-1:0]   bit_idx;
    logic            out_valid_r;
    logic [SW-1:0]   out_sample_r;

    logic            bit_end;
    logic            word_end;
    logic [IW-1:0]   k_ext;
    logic [IW-1:0]   dbl;
    logic [IW-1:0]   base;
    logic [IW-1:0]   sum;
    logic [LW-1:0]   lut_idx;
    logic [SW-1:0]   lut_sample;

    assign bit_end       = (k == K_LAST);
    assign word_end      = bit_end && (bit_idx == B_LAST);
    assign strm.in_ready = (state == IDLE) || (state == SEND && word_end);
    assign strm.out_valid  = out_valid_r;
    assign strm.out_sample = out_sample_r;
    assign busy          = (state == SEND);

    // A 1 bit walks half a period, a 0 bit a full period; phase=1 starts half a table later
    always_comb begin
        k_ext = IW'(k);
        dbl   = k_ext << 1;
        if (dbl >= P_I) begin
            dbl = dbl - P_I;
        end
        base = shreg[0] ? k_ext : dbl;
        sum  = base + (phase ? HALF_I : '0);
        if (sum >= P_I) begin
            sum = sum - P_I;
        end
        lut_idx = LW'(sum);
    end

    msk_sine_lut #(
        .SAMPLE_WIDTH    (SW),
        .SAMPLES_PER_BIT (N)
    ) u_lut (
        .idx    (lut_idx),
        .sample (lut_sample)
    );

    always_ff @(posedge G_CLK_TX or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= '0;
            k            <= '0;
            bit_idx      <= '0;
            phase        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_sample_r <= MID_S;
        end else if (clear) begin
            state        <= IDLE;
            shreg        <= '0;
            k            <= '0;
            bit_idx      <= '0;
            phase        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_sample_r <= MID_S;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    out_valid_r  <= 1'b0;
                    out_sample_r <= MID_S;
                    if (strm.in_valid) begin
                        shreg   <= strm.in_data;
                        k       <= '0;
                        bit_idx <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    out_valid_r  <= 1'b1;
                    out_sample_r <= lut_sample;
                    if (bit_end) begin
                        k     <= '0;
                        phase <= phase ^ shreg[0];
                        shreg <= shreg >> 1;
                        if (bit_idx == B_LAST) begin
                            bit_idx <= '0;
                            // in_ready is high here, so in_valid alone means accept
                            if (strm.in_valid) begin
                                shreg <= strm.in_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/msk_stream_modulator.md
# msk_stream_modulator

Parametrised, streaming MSK modulator for the TX path. It accepts data words over a valid/ready handshake and serialises them LSB-first. For each bit it emits `SAMPLES_PER_BIT` offset-binary sine samples toward the TX DAC. Carrier phase is continuous across bit and word boundaries, and back-to-back words are sent with no gap. It replaces the single-word, fixed-8-bit modulator with a generic width/oversampling block that has input flow control and underrun handling.

## Interface
- `DATA_WIDTH`, 8: bits per input word, ≥2.
- `SAMPLE_WIDTH`, 8: DAC sample width, 4..16.
- `SAMPLES_PER_BIT`, 32: samples per bit, N; power of 2, ≥8.
- `G_CLK_TX` input 1: TX clock; all state updates on its rising edge.
- `reset` input 1: reset, asynchronous, active-low.
- `enable` input 1: sample strobe; when low, all state, handshake and outputs hold.
- `clear` input 1: synchronous abort, honoured regardless of `enable`.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block can take a word this cycle.
- `in_data` input DATA_WIDTH: word to modulate; bit 0 is sent first.
- `out_valid` output 1: `out_sample` is a new sample this cycle.
- `out_sample` output SAMPLE_WIDTH: offset-binary sample.
- `busy` output 1: state is SEND.
- `phase` output 1: current carrier phase; 0 = 0 rad, 1 = π.

## Operation
- **Sine table.** Let P = 2·(N−1).
  - `table[i]` = MID + round(AMP·sin(2π·i/P)), for i in 0..P−1.
  - MID = 2^(SW−1); AMP = 2^(SW−1)−1. For SW=8 the range is 1..255.
- **Sample index** for sample k (0..N−1) of the current bit:
  - bit=1: base = k (half sine period per bit).
  - bit=0: base = 2k mod P (one full period per bit).
  - If `phase`=1, add N−1 (mod P).
- **Phase rule.** After the last sample of a bit equal to 1, `phase` toggles. A 0 bit leaves `phase` unchanged. `phase` persists across words. Only `reset` or `clear` return it to 0.
- **States:**
  - IDLE: `in_ready`=1. On accept (`enable` & `in_valid` & `in_ready`), load the shift register, set bit_idx=0 and k=0, and go to SEND.
  - SEND: each enabled cycle emits one sample and increments k.
    - At k=N−1: reset k to 0, apply the phase rule, and increment bit_idx.
    - At bit_idx=DW−1 and k=N−1, `in_ready`=1 this cycle. On accept, load the new word and stay in SEND with no gap. Otherwise go to IDLE.
  - `in_ready`=0 at every other point in SEND.
- **Underrun.** In IDLE, `out_valid`=0 and `out_sample`=MID. `phase` is retained.
- **`clear`.** Next state is IDLE, with `phase`=0, counters at 0, `out_valid`=0 and `out_sample`=MID. `clear` has priority over a simultaneous accept; that word is dropped and `in_ready` is still reported.
- **Widths.** k is $clog2(N) bits; bit_idx is $clog2(DW) bits. Index arithmetic uses a $clog2(P)+1-bit intermediate reduced mod P. No overflow wrap is ever relied on.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_sample`=MID, `busy`=0, `phase`=0.
- **Output registers.** `out_sample` and `out_valid` are registered. They are driven from the combinational table lookup on the SEND state.
- **Latency.** Accept at enabled edge E0. Sample k=0 of bit 0 appears after the next enabled edge E1. Sample j of the word appears after edge E1+j.
- **Throughput.** One word per DW·N enabled cycles when `in_valid` is held high. `out_valid` stays continuously 1 in that case.
- **`enable`.** `enable`=0 freezes everything, including `out_valid`; the hold is not a new sample. An accept requires `enable`=1.
- **Reset mid-word.** Immediate return to reset values, asynchronously. The partial word is lost.

## Structure
- **Package `msk_pkg`:**
  - state enum `msk_state_t` (IDLE, SEND);
  - function `msk_sine(i, P, SW)` returning the table value (elaboration-time);
  - constants MID and AMP as functions of SW.
- **Sub-module `msk_sine_lut`:**
  - parameters `SAMPLE_WIDTH` and `SAMPLES_PER_BIT`;
  - combinational; index in, sample out;
  - table built in a generate/initial loop from `msk_pkg::msk_sine`.
- **Top level:** FSM, counters, shift register, phase register and output registers.

## Test plan
All scenarios use the default parameters (DW=8, SW=8, N=32), so P=62 and MID=128.
- **Reset:** deassert `reset` → `in_ready`=1, `out_sample`=128, `out_valid`=0. Assert `reset` mid-SEND → same values immediately.
- **All zeros, in_data=0x00:** bit 0 samples k=0..3 = 128, 154, 178, 201. k=31 = 128. `phase` stays 0 through all 256 samples.
- **Phase flip, in_data=0x01:**
  - bit 0 (a 1): k=1 → 141, k=16 → 255.
  - Then `phase`=1, and bit 1 (a 0): k=1 → 102, k=2 → 78.
- **Back-to-back:** 0xFF then 0x00 with `in_valid` held high.
  - `in_ready` pulses exactly once, at sample 255.
  - `out_valid` has no gap.
  - `phase` at the start of word 2 = 0 (eight toggles).
- **Underrun / enable:**
  - No second word → `out_valid`=0 and `out_sample`=128 after sample 255.
  - `enable` low for 5 cycles mid-bit → sample stream resumes at the same k, and the total count is still 256.
- **`clear`:** assert `clear` at sample 40 of 0x01 → next cycle IDLE, `phase`=0, `out_sample`=128. A word offered in the same cycle is not sent.
